axi_stream_pin_sink: RTL and testbench
======================================

# axi_stream_pin_sink

AXI4-Stream slave that accepts 32-bit beats, buffers them in a 16-entry FIFO and serializes them onto an 8-bit pin bus, one byte per cycle, least-significant byte first. Bytes whose `tkeep` bit is clear are skipped. It is the transmit-side counterpart of the pin-to-stream source: the DMA/interconnect drives it, and the external pin interface consumes its output under a valid/ready strobe pair.

## Interface
- `FIFO_DEPTH_BITS`, 4: log2 of FIFO depth; depth = 16 entries of {tlast, tkeep[3:0], tdata[31:0]}.
- `aclk`  in  1  single clock; all logic on rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  input beat ready.
- `s_axis_tdata`  in  32  beat data; byte i = bits [8i+7:8i].
- `s_axis_tkeep`  in  4  per-byte keep; 0 bits are not emitted.
- `s_axis_tlast`  in  1  end of packet.
- `data_pins`  out  8  byte on pins.
- `pin_valid`  out  1  `data_pins` holds a valid byte.
- `pin_last`  out  1  byte is the last kept byte of a tlast beat.
- `pin_ready`  in  1  pin side accepts byte when `pin_valid && pin_ready`.

## Operation
- Accept: beat transfers on `s_axis_tvalid && s_axis_tready`. `s_axis_tready = !fifo_full && !areset`, derived from the registered count only. A pop in the same cycle does not open a slot.
- Null beats (`tkeep == 4'b0000`) are accepted and discarded, never written. Their `tlast` is dropped.
- FIFO: `wr_ptr` and `rd_ptr` are `FIFO_DEPTH_BITS` wide and wrap modulo 16. `fifo_count` is `FIFO_DEPTH_BITS+1` wide. A simultaneous push and pop leaves the count unchanged.
- Word register: holds the current word, its remaining keep mask, its last flag and `word_valid`.
- Output register: holds `data_pins`, `pin_valid` and `pin_last`. It advances when `!pin_valid || pin_ready`.
- On advance with `word_valid`:
  - Move the lowest-index byte whose mask bit is set into the output register and clear that bit.
  - `pin_last` = word last flag AND no mask bits remain.
- On advance without `word_valid`: `pin_valid` goes to 0.
- Word register loads the FIFO head (pop) when `!word_valid`, or when the current advance consumes its final kept byte. This gives back-to-back words with no bubble.
- State per word: IDLE (`!word_valid`) -> SHIFT (mask ≠ 0) -> IDLE or reload. No other states.
- While `pin_valid && !pin_ready`: `data_pins`, `pin_last` and the word register are held stable. No byte is lost or duplicated.
- Simulation-only checks (translate_off): error on push while full and on pop while empty.

## Timing
- Reset (sampled high at an edge): after that edge `s_axis_tready=0`, `pin_valid=0`, `pin_last=0`, `data_pins=8'h00`. Pointers, count, `word_valid` and mask are cleared.
- Reset mid-operation: all buffered data and in-flight bytes are discarded. Nothing is emitted after reset.
- First edge with `areset` low: `s_axis_tready` becomes 1 after that edge.
- Latency:
  - Beat accepted at edge k is in the FIFO after edge k.
  - It is in the word register after edge k+1.
  - Its first kept byte is on the pins (`pin_valid=1`) after edge k+2, with `pin_ready` high and the pipeline empty.
- Throughput: 1 byte/cycle sustained with `pin_ready` high. A word with n kept bytes occupies n cycles.
- Capacity with full-keep words and `pin_ready=0`: 16 FIFO entries + 1 word register = 17 beats accepted before `s_axis_tready` falls.

## Test plan
- Reset: hold `areset` 3 cycles with `tvalid=1` -> `tready=0`, `pin_valid=0`, `data_pins=00`, nothing accepted. `tready=1` one cycle after release.
- Single beat `0x44332211`, keep `F`, last 1, `pin_ready=1` -> `11,22,33,44` on 4 consecutive cycles starting 2 cycles after accept. `pin_last` only with `44`.
- Sparse keep: `0xDDCCBBAA` keep `4'b1010` last 1 -> `BB`, then `DD` with `pin_last=1`. A following keep-0 beat with last 1 -> accepted, no output.
- Backpressure: stream 3 full words and drop `pin_ready` for 5 cycles mid-word -> `data_pins`/`pin_last` stable during the stall. Output is exactly 12 bytes, in order.
- Full: `pin_ready=0`, offer 20 full-keep beats -> exactly 17 accepted, then `tready=0`. Raise `pin_ready` -> 68 bytes in order, and `tready` reasserts after the first pop.
- Reset mid-stream: assert `areset` for 1 cycle while 5 words are buffered -> `pin_valid=0` after the edge and no stale bytes emitted. A new beat `0x0A0B0C0D` afterwards produces `0D,0C,0B,0A`.

Source files
------------

// File: rtl/axi_stream_pin_sink.sv
// AXI4-Stream slave that buffers 32-bit beats in a FIFO and serializes their
// kept bytes, least-significant first, onto an 8-bit valid/ready pin bus.
module axi_stream_pin_sink #(
    parameter int FIFO_DEPTH_BITS = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    output logic [7:0]  data_pins,
    output logic        pin_valid,
    output logic        pin_last,
    input  logic        pin_ready
);

    localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
    localparam int ENTRY_W = 37;
    localparam logic [FIFO_DEPTH_BITS:0] DEPTH_CNT = (FIFO_DEPTH_BITS + 1)'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    logic [ENTRY_W-1:0]         fifo_mem_p0 [DEPTH];
    logic [ENTRY_W-1:0]         fifo_head_p0;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic                       in_reset;

    state_t      state;
    state_t      state_nxt;
    logic        word_valid;
    logic [31:0] word_data_p1;
    logic [3:0]  word_mask_p1;
    logic        word_last_p1;

    logic        advance;
    logic        take_byte;
    logic        final_byte;
    logic [1:0]  sel_idx;
    logic [3:0]  mask_after;

    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign fifo_empty = (fifo_count == '0);
    // in_reset keeps tready low until the first edge seen with areset released
    assign s_axis_tready = !fifo_full && !areset && !in_reset;
    assign push          = s_axis_tvalid && s_axis_tready && (s_axis_tkeep != 4'b0000);
    assign fifo_head_p0  = fifo_mem_p0[rd_ptr];

    assign word_valid = (state == SHIFT);
    assign advance    = !pin_valid || pin_ready;
    assign sel_idx    = lowest_idx(word_mask_p1);
    assign mask_after = word_mask_p1 & ~(4'b0001 << sel_idx);
    assign take_byte  = advance && word_valid;
    assign final_byte = take_byte && (mask_after == 4'b0000);
    assign pop        = (!word_valid || final_byte) && !fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (pop) state_nxt = SHIFT;
            SHIFT: if (final_byte) state_nxt = pop ? SHIFT : IDLE;
        endcase
    end

    // Stage p0: FIFO storage (data only, no reset)
    always_ff @(posedge aclk) begin
        if (push) fifo_mem_p0[wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end

    // Stage p1: word register payload loaded on pop
    always_ff @(posedge aclk) begin
        if (pop) begin
            word_data_p1 <= fifo_head_p0[31:0];
            word_last_p1 <= fifo_head_p0[36];
        end
    end

    // Control: pointers, count, word state/mask and the pin output register
    always_ff @(posedge aclk) begin
        if (areset) begin
            in_reset     <= 1'b1;
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            word_mask_p1 <= 4'b0000;
            pin_valid    <= 1'b0;
            pin_last     <= 1'b0;
            data_pins    <= 8'h00;
        end else begin
            in_reset <= 1'b0;
            state    <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            if (pop)            word_mask_p1 <= fifo_head_p0[35:32];
            else if (take_byte) word_mask_p1 <= mask_after;

            // Stage p2: pin output register
            if (advance) begin
                if (word_valid) begin
                    pin_valid <= 1'b1;
                    pin_last  <= word_last_p1 && (mask_after == 4'b0000);
                    data_pins <= byte_sel(word_data_p1, sel_idx);
                end else begin
                    pin_valid <= 1'b0;
                    pin_last  <= 1'b0;
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge aclk) begin
        if (!areset && push && fifo_full)
            $error("axi_stream_pin_sink: push while fifo full");
        if (!areset && pop && fifo_empty)
            $error("axi_stream_pin_sink: pop while fifo empty");
    end
`endif

endmodule

// File: tb/tb_axi_stream_pin_sink.sv
// Bench for axi_stream_pin_sink: byte-queue reference model plus directed and
// randomized stimulus.
module tb_axi_stream_pin_sink;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic [7:0]  data_pins;
    logic        pin_valid;
    logic        pin_last;
    logic        pin_ready;

    always #5 aclk = ~aclk;

    axi_stream_pin_sink #(.FIFO_DEPTH_BITS(4)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .data_pins     (data_pins),
        .pin_valid     (pin_valid),
        .pin_last      (pin_last),
        .pin_ready     (pin_ready)
    );

    typedef struct {
        int         c;
        logic [7:0] b;
        logic       l;
    } ev_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_count = 0;
    int         last_acc_cyc = 0;
    logic [8:0] exp_q[$];
    ev_t        out_log[$];
    bit         stall_pend = 0;
    logic [7:0] stall_d;
    logic       stall_l;
    logic [8:0] mon_e;
    int         mon_hi;
    bit         rand_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Reference model: every accepted beat appends its kept bytes to a queue;
    // every pin handshake must take the head of that queue.
    always @(negedge aclk) begin
        if (areset) begin
            exp_q.delete();
            stall_pend = 0;
            check("tready_in_reset", s_axis_tready, 1'b0);
        end else begin
            if (stall_pend) begin
                check("stall_valid", pin_valid, 1'b1);
                check("stall_data", data_pins, stall_d);
                check("stall_last", pin_last, stall_l);
            end
            stall_pend = 0;
            if (pin_valid && !pin_ready) begin
                stall_pend = 1;
                stall_d    = data_pins;
                stall_l    = pin_last;
            end
            if (pin_valid && pin_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_byte: got %0h expected no byte (cycle %0d)", data_pins, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pin_data", data_pins, mon_e[7:0]);
                    check("pin_last", pin_last, mon_e[8]);
                end
                out_log.push_back('{cyc, data_pins, pin_last});
            end
            if (s_axis_tvalid && s_axis_tready) begin
                acc_count++;
                last_acc_cyc = cyc + 1;
                mon_hi = -1;
                for (int i = 0; i < 4; i++) if (s_axis_tkeep[i]) mon_hi = i;
                for (int i = 0; i < 4; i++)
                    if (s_axis_tkeep[i])
                        exp_q.push_back({s_axis_tlast && (i == mon_hi), s_axis_tdata[8*i +: 8]});
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        bit done;
        t = 0;
        done = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        while (!done) begin
            @(negedge aclk);
            if (s_axis_tready) done = 1;
            @(posedge aclk);
            #1;
            if (!done) begin
                t++;
                if (t > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got no tready expected accept of %0h", d);
                    done = 1;
                end
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_log(input string name, input int n, input int bound);
        int t;
        t = 0;
        while (out_log.size() < n && t < bound) begin
            tick();
            t++;
        end
        check(name, out_log.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit acc;
        int t;
        logic [7:0] exp_b [4];

        areset        = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEADBEEF;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b1;
        pin_ready     = 1'b0;

        // Reset held three cycles with tvalid high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tready", s_axis_tready, 1'b0);
            check("rst_pin_valid", pin_valid, 1'b0);
            check("rst_pin_last", pin_last, 1'b0);
            check("rst_data_pins", data_pins, 8'h00);
        end
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        check("tready_before_first_low_edge", s_axis_tready, 1'b0);
        tick();
        check("tready_after_release", s_axis_tready, 1'b1);
        check("rst_nothing_accepted", acc_count, 0);

        // Single full beat: latency and byte order
        pin_ready = 1'b1;
        out_log.delete();
        send(32'h44332211, 4'hF, 1'b1);
        wait_log("single_count", 4, 20);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4 && i < out_log.size(); i++) begin
            check("single_byte", out_log[i].b, exp_b[i]);
            check("single_last", out_log[i].l, (i == 3));
            check("single_cycle", out_log[i].c, last_acc_cyc + 2 + i);
        end
        tick();
        tick();
        check("single_idle", pin_valid, 1'b0);

        // Sparse keep then a null beat
        out_log.delete();
        n = acc_count;
        send(32'hDDCCBBAA, 4'b1010, 1'b1);
        send(32'h12345678, 4'b0000, 1'b1);
        repeat (10) tick();
        check("sparse_accepted", acc_count - n, 2);
        check("sparse_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("sparse_b0", out_log[0].b, 8'hBB);
            check("sparse_l0", out_log[0].l, 1'b0);
            check("sparse_b1", out_log[1].b, 8'hDD);
            check("sparse_l1", out_log[1].l, 1'b1);
        end

        // Backpressure mid-word
        out_log.delete();
        send(32'h03020100, 4'hF, 1'b0);
        send(32'h07060504, 4'hF, 1'b0);
        send(32'h0B0A0908, 4'hF, 1'b1);
        tick();
        tick();
        pin_ready = 1'b0;
        repeat (5) tick();
        pin_ready = 1'b1;
        wait_log("bp_count", 12, 60);
        repeat (5) tick();
        check("bp_exact_count", out_log.size(), 12);
        for (int i = 0; i < 12 && i < out_log.size(); i++) begin
            check("bp_byte", out_log[i].b, 8'(i));
            check("bp_last", out_log[i].l, (i == 11));
        end

        // Fill: 17 full-keep beats fit with pin_ready low
        pin_ready = 1'b0;
        out_log.delete();
        n = 0;
        s_axis_tkeep = 4'hF;
        s_axis_tlast = 1'b0;
        for (int c = 0; c < 60 && n < 20; c++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
            @(negedge aclk);
            acc = s_axis_tready;
            @(posedge aclk);
            #1;
            if (acc) n++;
        end
        s_axis_tvalid = 1'b0;
        check("full_accepted", n, 17);
        check("full_tready_low", s_axis_tready, 1'b0);
        pin_ready = 1'b1;
        t = 0;
        while (!s_axis_tready && t < 20) begin
            tick();
            t++;
        end
        check("full_tready_reassert", s_axis_tready, 1'b1);
        wait_log("full_count", 68, 300);
        if (out_log.size() == 68) begin
            check("full_first", out_log[0].b, 8'h00);
            check("full_final", out_log[67].b, 8'h43);
        end

        // Reset while five words are buffered
        pin_ready = 1'b0;
        for (int i = 0; i < 5; i++) send({4{8'(8'h50 + i)}}, 4'hF, 1'b1);
        tick();
        check("pre_rst_valid", pin_valid, 1'b1);
        areset = 1'b1;
        tick();
        check("midrst_pin_valid", pin_valid, 1'b0);
        check("midrst_data", data_pins, 8'h00);
        check("midrst_tready", s_axis_tready, 1'b0);
        areset = 1'b0;
        out_log.delete();
        pin_ready = 1'b1;
        repeat (10) tick();
        check("midrst_no_stale", out_log.size(), 0);
        send(32'h0A0B0C0D, 4'hF, 1'b1);
        wait_log("midrst_new_count", 4, 20);
        exp_b = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            check("midrst_byte", out_log[i].b, exp_b[i]);

        // Randomized traffic with random pin backpressure
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    pin_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                pin_ready = 1'b1;
            end
        join
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        repeat (3) tick();
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", pin_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
